data_mem_responder: RTL

- Memory-side responder for the data-memory requests issued by the CPU control path on LDURSW and STURW instructions.
- Accepts one 32-bit word request (chip-select, write flag, byte address, write data) and splits it into two 16-bit accesses to an external asynchronous SRAM (2048x16), low half first.
- Returns read data or write completion with a one-cycle response pulse.
- Sits between ALU/register-file datapath and the SRAM pins.

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_mem_phase_timer.sv | 27 ++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the word-to-halfword SRAM responder.
package data_mem_responder_pkg;
  localparam int WORD_W              = 32;
  localparam int HALF_W              = 16;
  localparam int TIMER_W             = 3;
  localparam int DEFAULT_WAIT_STATES = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO_SETUP,
    ST_LO_ACT,
    ST_HI_SETUP,
    ST_HI_ACT,
    ST_RESP
  } state_e;
endpackage

// File: rtl/data_mem_responder_mem_phase_timer.sv
// Loadable down-counter that measures the length of one SRAM active phase.
module mem_phase_timer
  import data_mem_responder_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);
  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/data_mem_responder.sv
// Splits a 32-bit load/store request into two 16-bit async-SRAM accesses (low half first).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_cs,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic [ADDR_W-2:0] sram_addr,
  output logic [HALF_W-1:0] sram_wdata,
  input  logic [HALF_W-1:0] sram_rdata,
  output logic              sram_drive,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);
  localparam logic [TIMER_W-1:0] WS_LOAD = TIMER_W'(WAIT_STATES);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [ADDR_W-3:0]   waddr_q, waddr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [HALF_W-1:0]   lo_q, lo_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                timer_load, timer_done;
  logic                in_lo, in_hi, in_phase, in_act;

  mem_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (WS_LOAD),
    .done     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    err_d      = err_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_cs) begin
          write_d = req_write;
          waddr_d = req_addr[ADDR_W-1:2];
          wdata_d = req_wdata;
          err_d   = |req_addr[1:0];
          state_d = (|req_addr[1:0]) ? ST_RESP : ST_LO_SETUP;
        end
      end
      ST_LO_SETUP: begin
        timer_load = 1'b1;
        state_d    = ST_LO_ACT;
      end
      ST_LO_ACT: begin
        if (timer_done) begin
          if (!write_q) lo_d = sram_rdata;
          state_d = ST_HI_SETUP;
        end
      end
      ST_HI_SETUP: begin
        timer_load = 1'b1;
        state_d    = ST_HI_ACT;
      end
      ST_HI_ACT: begin
        // The low half is staged so rsp_rdata only changes once the whole word is in.
        if (timer_done) begin
          if (!write_q) rdata_d = {sram_rdata, lo_q};
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  // Pin outputs decode straight from the state flop so an async reset releases them at once.
  assign in_lo    = (state_q == ST_LO_SETUP) || (state_q == ST_LO_ACT);
  assign in_hi    = (state_q == ST_HI_SETUP) || (state_q == ST_HI_ACT);
  assign in_phase = in_lo || in_hi;
  assign in_act   = (state_q == ST_LO_ACT) || (state_q == ST_HI_ACT);

  assign sram_addr  = in_phase ? {waddr_q, in_hi} : '0;
  assign sram_wdata = in_hi ? wdata_q[WORD_W-1:HALF_W] : (in_lo ? wdata_q[HALF_W-1:0] : '0);
  assign sram_cs_n  = !in_phase;
  assign sram_we_n  = !(in_act && write_q);
  assign sram_oe_n  = !(in_act && !write_q);
  assign sram_drive = in_phase && write_q;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = (state_q == ST_RESP) && err_q;
  assign rsp_rdata = rdata_q;
endmodule
